// File: rtl/nic_pkg.sv
// Shared constants for the NIC controller slice: register map, data width, bit positions.
// No logic; pure declarations.
// Not applicable (no flow control in a package).
package nic_pkg;

  // Processor-visible register map, selected by the 2-bit addr.
  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  // Packet/data width. Buses are numbered [0:NIC_DATA_W-1], so bit 63 is the LSB.
  localparam int NIC_DATA_W = 64;

  // Status flags are returned in the LSB of the read word.
  localparam int NIC_STAT_BIT = 63;

  // Virtual-channel bit of a packet (the MSB in [0:63] numbering).
  localparam int NIC_VC_BIT = 0;

endpackage

// File: rtl/nic_channel_fifo.sv
// Generic circular FIFO for one NIC channel; head, full and nonempty come from registered state.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: push is ignored while full, pop ignored while empty; both may occur in one cycle.
module nic_channel_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [0:WIDTH-1] push_dat,
  input  logic             pop,
  output logic [0:WIDTH-1] head_dat,
  output logic             full,
  output logic             nonempty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [0:WIDTH-1] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic push_ok;
  logic pop_ok;

  // Qualify requests against the pre-edge flags so a full FIFO never accepts data,
  // even when it is being drained in the same cycle.
  assign full     = (count == FULL_CNT);
  assign nonempty = (count != '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && nonempty;

  // Head is forced to zero when empty so stale entries never leak out.
  assign head_dat = nonempty ? mem[rd_ptr] : '0;

  // Storage write; data needs no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy update; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nic_controller.sv
// NIC between the processor's polled register port and one router port, with an in and out channel FIFO.
// Latency: router packet readable the cycle after capture; processor store offered to the router the cycle after the write.
// Backpressure: net_ri drops while the input FIFO is full; writes to a full output FIFO are dropped; net_so waits for net_ro.
// Optional: define NIC_POLARITY_FILTER_EN to hold net_so until the head packet's VC bit matches net_polarity.
module nic_controller
  import nic_pkg::*;
#(
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 2,
  parameter int DATA_W    = NIC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:1]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  // Status flag lands in the LSB; tracks DATA_W if the width is overridden.
  localparam int STAT_BIT = NIC_STAT_BIT + DATA_W - NIC_DATA_W;

  logic              rd_en;
  logic              wr_en;
  logic [1:0]        reg_sel;

  logic              in_push;
  logic              in_pop;
  logic [0:DATA_W-1] in_head;
  logic              in_full;
  logic              in_nonempty;

  logic              out_push;
  logic              out_pop;
  logic [0:DATA_W-1] out_head;
  logic              out_full;
  logic              out_nonempty;

  assign reg_sel = addr;
  assign rd_en   = nicEn && !nicWrEn;
  assign wr_en   = nicEn && nicWrEn;

  // Router -> processor channel. net_ri is purely state-derived, so a pop in the
  // same cycle cannot open the input while it is full.
  assign net_ri  = !in_full;
  assign in_push = net_si && net_ri;
  assign in_pop  = rd_en && (reg_sel == NIC_ADDR_IN_BUF) && in_nonempty;

  nic_channel_fifo #(
    .DEPTH (IN_DEPTH),
    .WIDTH (DATA_W)
  ) u_in_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_push),
    .push_dat (net_di),
    .pop      (in_pop),
    .head_dat (in_head),
    .full     (in_full),
    .nonempty (in_nonempty)
  );

  // Processor -> router channel. A store to a full channel is silently lost;
  // software is expected to poll the out-status register first.
  assign out_push = wr_en && (reg_sel == NIC_ADDR_OUT_BUF) && !out_full;
  assign out_pop  = net_so && net_ro;
  assign net_do   = out_head;

  nic_channel_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (DATA_W)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (out_push),
    .push_dat (d_in),
    .pop      (out_pop),
    .head_dat (out_head),
    .full     (out_full),
    .nonempty (out_nonempty)
  );

`ifdef NIC_POLARITY_FILTER_EN
  // Offer the head only on cycles whose router polarity matches the packet's VC.
  assign net_so = out_nonempty && (out_head[NIC_VC_BIT] == net_polarity);
`else
  // Polarity is not used in this build; the head is offered whenever present.
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign net_so          = out_nonempty;
`endif

  // Combinational register read mux; zero whenever the port is not being read.
  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (reg_sel)
        NIC_ADDR_IN_BUF:   d_out = in_head;
        NIC_ADDR_IN_STAT:  d_out[STAT_BIT] = in_nonempty;
        NIC_ADDR_OUT_BUF:  d_out = '0;
        NIC_ADDR_OUT_STAT: d_out[STAT_BIT] = out_full;
        default:           d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_controller.sv
// Directed self-checking bench for nic_controller with default depths of two.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Expected values are hand-derived constants per scenario.
module tb_nic_controller;

  logic        clk;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int pass_cnt;
  int total_cnt;

  nic_controller dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and step just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
    addr    = 2'b00;
    d_in    = '0;
    net_si  = 1'b0;
    net_di  = '0;
    net_ro  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    addr    = a;
    #1;
  endtask

  task automatic test_reset();
    idle();
    net_polarity = 1'b0;
    reset = 1'b1;
    #3;
    total_cnt++;
    if (d_out !== 64'd0 || net_ri !== 1'b1 || net_so !== 1'b0 || net_do !== 64'd0)
      $display("FAIL reset_state: d_out=%h net_ri=%b net_so=%b net_do=%h, want 0/1/0/0", d_out, net_ri, net_so, net_do);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    // Mid-transfer: capture 0xA5 from the router and a store toward it.
    net_si = 1'b1; net_di = 64'hA5;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h55;
    tick();
    idle();
    rd(2'b01);
    total_cnt++;
    if (d_out !== 64'd1 || net_so !== 1'b1)
      $display("FAIL reset_pre: d_out=%h net_so=%b, want 1/1", d_out, net_so);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (d_out !== 64'd0 || net_ri !== 1'b1 || net_so !== 1'b0 || net_do !== 64'd0)
      $display("FAIL reset_async: d_out=%h net_ri=%b net_so=%b net_do=%h, want 0/1/0/0", d_out, net_ri, net_so, net_do);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    rd(2'b00);
    total_cnt++;
    if (d_out !== 64'd0) $display("FAIL reset_inbuf: got %h want 0", d_out);
    else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_rx_to_proc();
    net_si = 1'b1; net_di = 64'h1234;
    tick();
    idle();
    #1;
    total_cnt++;
    if (d_out !== 64'd0) $display("FAIL rx_en_off: got %h want 0", d_out);
    else pass_cnt++;
    rd(2'b01);
    total_cnt++;
    if (d_out !== 64'd1) $display("FAIL rx_status: got %h want 1", d_out);
    else pass_cnt++;
    rd(2'b00);
    total_cnt++;
    if (d_out !== 64'h1234) $display("FAIL rx_data: got %h want 1234", d_out);
    else pass_cnt++;
    tick();
    rd(2'b01);
    total_cnt++;
    if (d_out !== 64'd0) $display("FAIL rx_status_after: got %h want 0", d_out);
    else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_in_backpressure();
    net_si = 1'b1; net_di = 64'h1;
    tick();
    total_cnt++;
    if (net_ri !== 1'b1) $display("FAIL bp_ri_one: got %b want 1", net_ri);
    else pass_cnt++;
    net_di = 64'h2;
    tick();
    total_cnt++;
    if (net_ri !== 1'b0) $display("FAIL bp_ri_full: got %b want 0", net_ri);
    else pass_cnt++;
    net_di = 64'h3;
    tick();
    tick();
    idle();
    rd(2'b00);
    total_cnt++;
    if (d_out !== 64'h1) $display("FAIL bp_first: got %h want 1", d_out);
    else pass_cnt++;
    tick();
    rd(2'b00);
    total_cnt++;
    if (d_out !== 64'h2) $display("FAIL bp_second: got %h want 2", d_out);
    else pass_cnt++;
    tick();
    rd(2'b01);
    total_cnt++;
    if (d_out !== 64'd0) $display("FAIL bp_empty: got %h want 0 (0x3 must not be captured)", d_out);
    else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_tx_to_router();
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'hDEADBEEF;
    #1;
    total_cnt++;
    if (net_so !== 1'b0) $display("FAIL tx_latency: net_so=%b want 0 before edge", net_so);
    else pass_cnt++;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (net_so !== 1'b1 || net_do !== 64'hDEADBEEF)
        $display("FAIL tx_hold%0d: net_so=%b net_do=%h want 1/deadbeef", i, net_so, net_do);
      else pass_cnt++;
      tick();
    end
    rd(2'b10);
    total_cnt++;
    if (d_out !== 64'd0) $display("FAIL tx_outbuf_read: got %h want 0", d_out);
    else pass_cnt++;
    net_ro = 1'b1;
    tick();
    net_ro = 1'b0;
    rd(2'b11);
    total_cnt++;
    if (net_so !== 1'b0 || d_out !== 64'd0)
      $display("FAIL tx_popped: net_so=%b status=%h want 0/0", net_so, d_out);
    else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_out_overflow();
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10;
    d_in = 64'h1;
    tick();
    rd(2'b11);
    total_cnt++;
    if (d_out !== 64'd0) $display("FAIL ovf_not_full: got %h want 0", d_out);
    else pass_cnt++;
    nicWrEn = 1'b1; d_in = 64'h2; addr = 2'b10;
    tick();
    rd(2'b11);
    total_cnt++;
    if (d_out !== 64'd1) $display("FAIL ovf_full: got %h want 1", d_out);
    else pass_cnt++;
    nicWrEn = 1'b1; d_in = 64'h3; addr = 2'b10;
    tick();
    idle();
    net_ro = 1'b1;
    #1;
    total_cnt++;
    if (net_so !== 1'b1 || net_do !== 64'h1) $display("FAIL ovf_drain1: so=%b do=%h want 1/1", net_so, net_do);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (net_so !== 1'b1 || net_do !== 64'h2) $display("FAIL ovf_drain2: so=%b do=%h want 1/2", net_so, net_do);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (net_so !== 1'b0 || net_do !== 64'd0) $display("FAIL ovf_no3: so=%b do=%h want 0/0", net_so, net_do);
    else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    // Input: push and pop together at count 1 keeps count at 1.
    net_si = 1'b1; net_di = 64'h10;
    tick();
    net_di = 64'h11;
    rd(2'b00);
    total_cnt++;
    if (d_out !== 64'h10) $display("FAIL b2b_in_head: got %h want 10", d_out);
    else pass_cnt++;
    tick();
    net_si = 1'b0;
    rd(2'b00);
    total_cnt++;
    if (d_out !== 64'h11 || net_ri !== 1'b1) $display("FAIL b2b_in_same: d_out=%h ri=%b want 11/1", d_out, net_ri);
    else pass_cnt++;
    tick();
    // Input full: a pop does not admit the router packet in the same cycle.
    idle();
    net_si = 1'b1; net_di = 64'h20;
    tick();
    net_di = 64'h21;
    tick();
    net_di = 64'h22;
    rd(2'b00);
    tick();
    net_si = 1'b0;
    rd(2'b00);
    total_cnt++;
    if (d_out !== 64'h21) $display("FAIL b2b_in_full_head: got %h want 21", d_out);
    else pass_cnt++;
    tick();
    rd(2'b01);
    total_cnt++;
    if (d_out !== 64'd0) $display("FAIL b2b_in_full_drop: got %h want 0", d_out);
    else pass_cnt++;
    idle();
    // Output: write while full alongside a drain is still lost.
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h7;
    tick();
    d_in = 64'h8;
    tick();
    d_in = 64'h9; net_ro = 1'b1;
    tick();
    idle();
    net_ro = 1'b1;
    #1;
    total_cnt++;
    if (net_do !== 64'h8) $display("FAIL b2b_out_full_head: got %h want 8", net_do);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (net_so !== 1'b0) $display("FAIL b2b_out_full_drop: net_so=%b want 0", net_so);
    else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_polarity();
    net_polarity = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h8000_0000_0000_00C1;
    tick();
    idle();
    net_ro = 1'b1;
    #1;
`ifdef NIC_POLARITY_FILTER_EN
    total_cnt++;
    if (net_so !== 1'b0) $display("FAIL pol_block: net_so=%b want 0", net_so);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (net_do !== 64'h8000_0000_0000_00C1) $display("FAIL pol_held: got %h want 80000000000000c1", net_do);
    else pass_cnt++;
    net_polarity = 1'b1;
    #1;
    total_cnt++;
    if (net_so !== 1'b1) $display("FAIL pol_match: net_so=%b want 1", net_so);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (net_so !== 1'b0 || net_do !== 64'd0) $display("FAIL pol_popped: so=%b do=%h want 0/0", net_so, net_do);
    else pass_cnt++;
`else
    total_cnt++;
    if (net_so !== 1'b1) $display("FAIL pol_ignored: net_so=%b want 1", net_so);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (net_so !== 1'b0) $display("FAIL pol_popped: net_so=%b want 0", net_so);
    else pass_cnt++;
`endif
    idle();
    net_polarity = 1'b0;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_rx_to_proc();
    test_in_backpressure();
    test_tx_to_router();
    test_out_overflow();
    test_back_to_back();
    test_polarity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/nic_controller.md
Name: nic_controller

Overview:
- Network interface controller between the four-stage processor's NIC port and one local port of the mesh router.
- Holds two buffered channels:
  - input channel: router → processor
  - output channel: processor → router
- Exposes buffer data and status to the processor through a 2-bit register address.
- Sequences a ready/send handshake toward the router so the processor can do polled load/store messaging.

Parameters:
- IN_DEPTH, 2, input channel FIFO entries (power of two, ≥1)
- OUT_DEPTH, 2, output channel FIFO entries (power of two, ≥1)
- DATA_W, 64, packet/data width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  [0:1]  processor register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
- d_in  in  [0:63]  processor write data
- d_out  out  [0:63]  processor read data
- nicEn  in  1  processor access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_si  in  1  router sends a packet to the NIC
- net_ri  out  1  NIC can accept a packet from the router
- net_di  in  [0:63]  packet from the router
- net_so  out  1  NIC sends a packet to the router
- net_ro  in  1  router can accept a packet
- net_do  out  [0:63]  packet to the router
- net_polarity  in  1  router's current even/odd cycle polarity

Behaviour:
- Reset (async, any time): both FIFOs empty, pointers/counts 0. Outputs: d_out=0, net_ri=1, net_so=0, net_do=0. Any buffered packets are discarded.
- Bit 63 is the LSB. Bit 0 is the packet VC bit.
- Processor reads (nicEn=1, nicWrEn=0) are combinational, with d_out valid the same cycle:
  - 00 → input FIFO head data (0 if empty)
  - 01 → {63'b0, in_nonempty}
  - 10 → 0
  - 11 → {63'b0, out_full}
  - When nicEn=0, d_out=0.
- Read of addr 00 while the input FIFO is non-empty pops the head at the next posedge. A read of 00 while empty has no effect.
- Processor writes (nicEn=1, nicWrEn=1):
  - Write to 10 while !out_full pushes d_in at the posedge.
  - Write to 10 while full is dropped silently; software must poll 11 first.
  - Writes to 00, 01 and 11 are ignored.
- Router input:
  - net_ri = !in_full (registered-state derived, no combinational path from net_si).
  - net_si & net_ri pushes net_di at the posedge.
  - net_si while !net_ri is a router protocol violation; the packet is not captured.
- Router output:
  - net_do = output FIFO head (0 if empty).
  - net_so = out_nonempty (see optional feature).
  - net_so & net_ro pops the head at the posedge.
- Simultaneous events:
  - Input FIFO, push and pop in the same cycle: both happen; count is unchanged. With in_full, a pop this cycle does not enable a push this cycle, because net_ri is already low.
  - Output FIFO, push and pop in the same cycle: both happen. A write while full in the same cycle as a drain is still dropped, since the full flag is sampled pre-edge.
- Pointers wrap modulo depth. The count has one extra bit; full = (count==DEPTH), nonempty = (count!=0).
- Latency:
  - Router packet visible to a processor read the cycle after capture.
  - Processor store visible on net_so the cycle after the write.

Optional Feature:
- NIC_POLARITY_FILTER_EN
- Defined: net_so = out_nonempty & (head[0] == net_polarity). A packet waits until the router polarity matches its VC bit. Pops occur only when net_so & net_ro.
- Undefined: net_polarity is ignored and net_so = out_nonempty.

Decomposition:
- Shared package nic_pkg holds:
  - address constants NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10, NIC_ADDR_OUT_STAT=2'b11
  - DATA_W default
  - status bit position (63)
- One sub-module, nic_channel_fifo: parameterised depth/width, push/pop/head/full/nonempty. It is instantiated twice.
- nic_controller itself holds only the address decode, handshake logic and polarity filter.

Test Plan:
- Reset mid-transfer: router pushes 0xA5 then reset pulses asynchronously between edges → d_out=0, net_ri=1, net_so=0 immediately; status read 01 returns 0.
- Router to processor: net_si=1, net_di=0x1234 for one cycle → read 01 returns 1; read 00 returns 0x1234; next cycle read 01 returns 0.
- Input back-pressure with IN_DEPTH=2: router pushes 0x1, 0x2 → net_ri=0; net_si held with 0x3 is not captured; processor reads return 0x1 then 0x2.
- Processor to router: write 10 with 0xDEADBEEF, net_ro=0 for 3 cycles → net_so=1 and net_do stable at 0xDEADBEEF. net_ro=1 → popped; read 11 returns 0.
- Output overflow: three writes (0x1, 0x2, 0x3) with net_ro=0 → read 11 returns 1 after the second; drain order is 0x1, 0x2; 0x3 is never sent.
- Polarity, with NIC_POLARITY_FILTER_EN: write packet with bit0=1, net_polarity=0, net_ro=1 → net_so=0. Toggle net_polarity=1 → net_so=1 and the packet pops that edge.
